// File: rtl/bird_pkg.sv
// Shared types and widths for the flappy-bird physics block.
package bird_pkg;
   localparam int COORD_W = 12;
   localparam int VEL_W   = 8;

   typedef enum logic [1:0] {
      READY = 2'd0,
      FLY   = 2'd1,
      DEAD  = 2'd2
   } state_t;
endpackage

// File: rtl/flap_edge_sync.sv
// Brings the raw flap button into the clock domain and emits a one-cycle pulse per rising edge.
module flap_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic flap_async,
   output logic flap_edge
);
   logic sync1, sync2, prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= flap_async;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign flap_edge = sync2 & ~prev;
endmodule

// File: rtl/bird_physics.sv
// Bird vertical physics: READY/FLY/DEAD state machine stepped on each tick.
// Bounding box outputs are registered and track the state registers.
module bird_physics
   import bird_pkg::*;
#(
   parameter int H_SIZE = 20,
   parameter int IX     = 160,
   parameter int IY     = 120,
   parameter int GRAV   = 1,
   parameter int FLAP_V = -8,
   parameter int VMAX   = 10,
   parameter int Y_MAX  = 465
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tick,
   input  logic               i_flap,
   input  logic               i_kill,
   output logic [COORD_W-1:0] o_x1,
   output logic [COORD_W-1:0] o_x2,
   output logic [COORD_W-1:0] o_y1,
   output logic [COORD_W-1:0] o_y2,
   output logic               o_out_of_bounds,
   output logic [1:0]         o_state
);
   state_t                    state, state_d;
   logic [COORD_W-1:0]        y, y_d, y_nx;
   logic signed [VEL_W-1:0]   v, v_d, v_nx, v_step;
   logic signed [VEL_W:0]     v_inc;
   logic signed [COORD_W:0]   y_sum;
   logic                      pending, pending_d, oob, oob_d;
   logic                      flap_edge, pend_eff, die;

   flap_edge_sync u_flap_sync (
      .clk        (i_clk),
      .rst_n      (i_rst),
      .flap_async (i_flap),
      .flap_edge  (flap_edge)
   );

   // One physics step, computed every cycle and used only when the FSM commits it.
   always_comb begin
      pend_eff = pending | flap_edge;
      v_inc    = {v[VEL_W-1], v} + (VEL_W+1)'(GRAV);
      v_step   = pend_eff ? VEL_W'(FLAP_V)
               : ((v_inc > VMAX) ? VEL_W'(VMAX) : v_inc[VEL_W-1:0]);
      y_sum    = $signed({1'b0, y}) + {{(COORD_W+1-VEL_W){v_step[VEL_W-1]}}, v_step};
      die      = 1'b0;
      y_nx     = y_sum[COORD_W-1:0];
      v_nx     = v_step;
      if (y_sum < H_SIZE) begin
         y_nx = COORD_W'(H_SIZE);
         v_nx = '0;
      end else if (y_sum + H_SIZE >= Y_MAX) begin
         y_nx = COORD_W'(Y_MAX - H_SIZE);
         die  = 1'b1;
      end
   end

   always_comb begin
      state_d   = state;
      y_d       = y;
      v_d       = v;
      pending_d = pending | flap_edge;
      oob_d     = oob;
      case (state)
         READY: begin
            if (i_tick && pend_eff) begin
               pending_d = 1'b0;
               y_d       = y_nx;
               v_d       = v_nx;
               state_d   = die ? DEAD : FLY;
               oob_d     = die;
            end
         end
         FLY: begin
            if (i_kill) begin
               state_d   = DEAD;
               pending_d = 1'b0;
            end else if (i_tick) begin
               pending_d = 1'b0;
               y_d       = y_nx;
               v_d       = v_nx;
               if (die) begin
                  state_d = DEAD;
                  oob_d   = 1'b1;
               end
            end
         end
         DEAD: begin
            // The reviving flap is consumed so it does not also launch the bird.
            pending_d = 1'b0;
            if (flap_edge) begin
               state_d = READY;
               y_d     = COORD_W'(IY);
               v_d     = '0;
               oob_d   = 1'b0;
            end
         end
         default: state_d = READY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state           <= READY;
         y               <= COORD_W'(IY);
         v               <= '0;
         pending         <= 1'b0;
         oob             <= 1'b0;
         o_x1            <= COORD_W'(IX - H_SIZE);
         o_x2            <= COORD_W'(IX + H_SIZE);
         o_y1            <= COORD_W'(IY - H_SIZE);
         o_y2            <= COORD_W'(IY + H_SIZE);
      end else begin
         state           <= state_d;
         y               <= y_d;
         v               <= v_d;
         pending         <= pending_d;
         oob             <= oob_d;
         o_x1            <= COORD_W'(IX - H_SIZE);
         o_x2            <= COORD_W'(IX + H_SIZE);
         o_y1            <= y_d - COORD_W'(H_SIZE);
         o_y2            <= y_d + COORD_W'(H_SIZE);
      end
   end

   assign o_state         = state;
   assign o_out_of_bounds = oob;
endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics with directed flap/tick/kill sequences.
module tb_bird_physics;
   logic        clk = 1'b0, rst = 1'b0, tick = 1'b0, flap = 1'b0, kill = 1'b0;
   logic [11:0] o_x1, o_x2, o_y1, o_y2;
   logic        o_oob;
   logic [1:0]  o_state;

   localparam logic [1:0] S_READY = 2'd0, S_FLY = 2'd1, S_DEAD = 2'd2;
   localparam int FALL_Y [18] = '{105, 99, 94, 90, 87, 85, 84, 84, 85, 87,
                                  90, 94, 99, 105, 112, 120, 129, 139};

   typedef struct packed {
      logic [1:0]  st;
      logic        oob;
      logic [11:0] x1, x2, y1, y2;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];
   int    checks = 0, failures = 0;
   logic  mon_en = 1'b0;
   event  async_chk;

   bird_physics dut (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_flap(flap), .i_kill(kill),
      .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
      .o_out_of_bounds(o_oob), .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic push_exp(string nm, logic [1:0] st, int y, logic oob);
      obs_t e;
      e.st  = st;
      e.oob = oob;
      e.x1  = 12'd140;
      e.x2  = 12'd180;
      e.y1  = 12'(y - 20);
      e.y2  = 12'(y + 20);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic check_front();
      obs_t  act, e;
      string nm;
      act = '{st: o_state, oob: o_oob, x1: o_x1, x2: o_x2, y1: o_y1, y2: o_y2};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_sample: no expectation queued, got st=%0d y1=%0d", o_state, o_y1);
      end else begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (act !== e) begin
            failures++;
            $display("FAIL %s: got st=%0d oob=%0d x=%0d..%0d y=%0d..%0d, required st=%0d oob=%0d x=%0d..%0d y=%0d..%0d",
                     nm, act.st, act.oob, act.x1, act.x2, act.y1, act.y2,
                     e.st, e.oob, e.x1, e.x2, e.y1, e.y2);
         end
      end
   endtask

   // Monitor: outputs are sampled shortly after any edge the stimulus marked as an update.
   always @(posedge clk) if (mon_en) begin
      #2;
      check_front();
   end

   always @(async_chk) begin
      #1;
      check_front();
   end

   task automatic do_tick(logic k, string nm, logic [1:0] st, int y, logic oob);
      @(negedge clk);
      tick = 1'b1; kill = k; mon_en = 1'b1;
      push_exp(nm, st, y, oob);
      @(negedge clk);
      tick = 1'b0; kill = 1'b0; mon_en = 1'b0;
   endtask

   // The synchronised edge is seen by the core two edges after flap rises; tick/kill line up with it.
   task automatic flap_pulse(logic t, logic k, logic chk, string nm,
                             logic [1:0] st, int y, logic oob);
      @(negedge clk);
      flap = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tick = t; kill = k; mon_en = chk;
      if (chk) push_exp(nm, st, y, oob);
      @(negedge clk);
      tick = 1'b0; kill = 1'b0; mon_en = 1'b0; flap = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      push_exp("reset", S_READY, 120, 1'b0);
      -> async_chk;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 5; i++)
         do_tick(i == 2, "idle_ready", S_READY, 120, 1'b0);

      flap_pulse(1'b0, 1'b0, 1'b0, "", S_READY, 120, 1'b0);
      flap_pulse(1'b0, 1'b0, 1'b0, "", S_READY, 120, 1'b0);
      do_tick(1'b0, "first_flap", S_FLY, 112, 1'b0);
      for (int i = 0; i < 18; i++)
         do_tick(1'b0, "glide", S_FLY, FALL_Y[i], 1'b0);
      for (int i = 0; i < 30; i++)
         do_tick(1'b0, "sat_fall", S_FLY, 149 + 10 * i, 1'b0);
      do_tick(1'b0, "floor", S_DEAD, 445, 1'b1);
      do_tick(1'b1, "dead_kill_ignored", S_DEAD, 445, 1'b1);

      flap_pulse(1'b0, 1'b0, 1'b1, "revive", S_READY, 120, 1'b0);
      do_tick(1'b0, "ready_after_revive", S_READY, 120, 1'b0);

      flap_pulse(1'b1, 1'b0, 1'b1, "launch", S_FLY, 112, 1'b0);
      for (int i = 1; i <= 11; i++)
         flap_pulse(1'b1, 1'b0, 1'b1, "flap_up", S_FLY, 112 - 8 * i, 1'b0);
      flap_pulse(1'b1, 1'b0, 1'b1, "top_clamp", S_FLY, 20, 1'b0);
      flap_pulse(1'b1, 1'b0, 1'b1, "top_clamp_again", S_FLY, 20, 1'b0);
      do_tick(1'b0, "after_clamp_v0", S_FLY, 21, 1'b0);

      flap_pulse(1'b1, 1'b1, 1'b1, "kill_beats_flap", S_DEAD, 21, 1'b0);
      do_tick(1'b0, "dead_hold", S_DEAD, 21, 1'b0);
      flap_pulse(1'b0, 1'b0, 1'b1, "revive2", S_READY, 120, 1'b0);
      flap_pulse(1'b1, 1'b0, 1'b1, "launch2", S_FLY, 112, 1'b0);
      do_tick(1'b0, "fly2", S_FLY, 105, 1'b0);

      @(negedge clk);
      rst = 1'b0;
      push_exp("async_reset", S_READY, 120, 1'b0);
      -> async_chk;
      @(negedge clk);
      rst = 1'b1;
      do_tick(1'b0, "post_reset_tick", S_READY, 120, 1'b0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: time limit reached, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
